// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared constants and FSM state type for the SPI register slave
// No ports: register addresses, command width and frame state encoding.
package spi_reg_pkg;

  localparam int CMD_W = 8;

  localparam logic [6:0] ADDR_ID     = 7'h00;
  localparam logic [6:0] ADDR_CTRL   = 7'h01;
  localparam logic [6:0] ADDR_COUNT  = 7'h02;
  localparam logic [6:0] ADDR_STATUS = 7'h03;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detect
// Ports: clk, rst (async high); din asynchronous input;
//        sync synchronised level, rise/fall one-clk edge pulses aligned with sync.
module spi_sync_edge #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] sr;

  // Resets to 0 so a select already held low across reset is not seen as
  // a falling edge; a frame can only start on a fresh ssel fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[DEPTH-2:0], din};
  end

  assign sync = sr[DEPTH-2];
  assign rise = sr[DEPTH-2] & ~sr[DEPTH-1];
  assign fall = ~sr[DEPTH-2] & sr[DEPTH-1];

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 slave with addressed register file
// Ports: clk, rst (async high); sck, ssel (active low), mosi from the MCU;
//        miso to the MCU; ctrl control outputs; wr_stb/wr_addr write-commit strobe.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(8'h01),
  parameter logic [31:0]       ID_VALUE = 32'h5A1C_0002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ssel,
  input  logic              mosi,
  output logic              miso,
  output logic [CTRL_W-1:0] ctrl,
  output logic              wr_stb,
  output logic [6:0]        wr_addr
);

  state_t            state, state_nxt;
  logic [5:0]        bit_cnt;
  logic [CMD_W-1:0]  cmd_sr;
  logic [DATA_W-1:0] rx_sr, tx_sr, count, rd_data;
  logic [31:0]       rd_wide;
  logic [15:0]       frame_cnt;
  logic              err;
  logic              cmd_done, data_done;
  logic [1:0]        mosi_ff;
  logic              sck_sync, sck_rise, sck_fall;
  logic              ssel_sync, ssel_rise, ssel_fall;
  logic              sck_act_rise, sck_act_fall;

  spi_sync_edge #(.DEPTH(3)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.DEPTH(3)) u_ssel_sync (
    .clk(clk), .rst(rst), .din(ssel),
    .sync(ssel_sync), .rise(ssel_rise), .fall(ssel_fall)
  );

  // sck edges only count while the select is (synchronously) asserted.
  assign sck_act_rise = sck_rise & ~ssel_sync;
  assign sck_act_fall = sck_fall & ~ssel_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ssel_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (ssel_fall && !sck_sync) state_nxt = CMD;
        CMD:     if (sck_act_rise && bit_cnt == 6'(CMD_W - 1)) state_nxt = DATA;
        DATA:    if (sck_act_rise && bit_cnt == 6'(DATA_W - 1)) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_wide = '0;
    case (cmd_sr[6:0])
      ADDR_ID:     rd_wide = ID_VALUE;
      ADDR_CTRL:   rd_wide[CTRL_W-1:0] = ctrl;
      ADDR_COUNT:  rd_wide[DATA_W-1:0] = count;
      ADDR_STATUS: rd_wide[16:0] = {err, frame_cnt};
      default:     ;
    endcase
  end

  assign rd_data = rd_wide[DATA_W-1:0];

  // The MSB is presented from the load until the first data sample; bits
  // past the data phase are never driven.
  assign miso = (state == DATA) ? tx_sr[DATA_W-1] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
      mosi_ff   <= '0;
      count     <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
      ctrl      <= CTRL_RST;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
    end else begin
      mosi_ff   <= {mosi_ff[0], mosi};
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
      wr_stb    <= 1'b0;
      count     <= count + DATA_W'(1);

      if (ssel_rise && (state == CMD || state == DATA)) err <= 1'b1;
      if (state == DATA && state_nxt == DONE) frame_cnt <= frame_cnt + 16'd1;

      case (state)
        IDLE: if (state_nxt == CMD) begin
          bit_cnt <= '0;
          tx_sr   <= '0;
        end
        CMD: if (sck_act_rise) begin
          cmd_sr <= {cmd_sr[CMD_W-2:0], mosi_ff[1]};
          if (state_nxt == DATA) begin
            bit_cnt  <= '0;
            cmd_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        DATA: begin
          if (sck_act_rise) begin
            rx_sr   <= {rx_sr[DATA_W-2:0], mosi_ff[1]};
            bit_cnt <= bit_cnt + 6'd1;
            if (state_nxt == DONE) data_done <= 1'b1;
          end else if (sck_act_fall && bit_cnt != '0) begin
            // The fall right after the command byte must not shift: the
            // freshly loaded MSB has not been sampled yet.
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase

      // Load one clk after the command byte; count here is the snapshot.
      if (cmd_done) tx_sr <= cmd_sr[CMD_W-1] ? '0 : rd_data;

      if (data_done && cmd_sr[CMD_W-1]) begin
        case (cmd_sr[6:0])
          ADDR_CTRL: begin
            ctrl    <= rx_sr[CTRL_W-1:0];
            wr_stb  <= 1'b1;
            wr_addr <= cmd_sr[6:0];
          end
          ADDR_COUNT: begin
            count   <= rx_sr;
            wr_stb  <= 1'b1;
            wr_addr <= cmd_sr[6:0];
          end
          ADDR_STATUS: begin
            frame_cnt <= '0;
            err       <= 1'b0;
            wr_stb    <= 1'b1;
            wr_addr   <= cmd_sr[6:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - self-checking bench for spi_reg_slave
// Ports: none (top-level bench).
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       rst, sck, ssel, mosi;
  logic       miso;
  logic [7:0] ctrl;
  logic       wr_stb;
  logic [6:0] wr_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stb_total = 0;
  int stb_cyc = 0;
  int raise8_cyc = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] wd;
    int          nd;
    logic [31:0] exp_rd;
    bit          chk_rd;
    int          stb;
    logic [6:0]  addr;
    logic [7:0]  ctrl;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    int          stb;
    logic [6:0]  addr;
    logic [7:0]  ctrl;
  } exp_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  exp_t sb[$];

  spi_reg_slave #(
    .DATA_W(32), .CTRL_W(8), .CTRL_RST(8'h01), .ID_VALUE(32'h5A1C_0002)
  ) dut (
    .clk(clk), .rst(rst), .sck(sck), .ssel(ssel), .mosi(mosi),
    .miso(miso), .ctrl(ctrl), .wr_stb(wr_stb), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_total <= stb_total + 1;
      stb_cyc   <= cyc;
    end
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Mode-0 master: mosi changes while sck is low, miso sampled just before
  // each rising edge. Sends nd data bits (MSB first) after the command.
  task automatic xfer(input logic [7:0] cmd, input logic [31:0] wd, input int nd,
                      input bit end_frame, output logic [31:0] rd);
    logic [39:0] sh;
    sh = {cmd, wd};
    rd = '0;
    ssel = 1'b0;
    half();
    for (int i = 0; i < 8 + nd; i++) begin
      mosi = sh[39 - i];
      half();
      if (i >= 8) rd = {rd[30:0], miso};
      if (i == 7) raise8_cyc = cyc;
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
    if (end_frame) begin
      half();
      ssel = 1'b1;
      half();
      half();
    end
  endtask

  initial begin
    logic [31:0] rd, d;
    exp_t        e;
    int          s0, lo;

    vecs[0]  = '{8'h00, 32'h0,        32, 32'h5A1C0002, 1'b1, 0, 7'h00, 8'h01};
    vecs[1]  = '{8'h81, 32'h000000A5, 32, 32'h0,        1'b0, 1, 7'h01, 8'hA5};
    vecs[2]  = '{8'h01, 32'h0,        32, 32'h000000A5, 1'b1, 0, 7'h00, 8'hA5};
    vecs[3]  = '{8'h03, 32'h0,        32, 32'h00000003, 1'b1, 0, 7'h00, 8'hA5};
    vecs[4]  = '{8'h81, 32'h000000FF, 20, 32'h0,        1'b0, 0, 7'h00, 8'hA5};
    vecs[5]  = '{8'h03, 32'h0,        32, 32'h00010004, 1'b1, 0, 7'h00, 8'hA5};
    vecs[6]  = '{8'h85, 32'h12345678, 32, 32'h0,        1'b0, 0, 7'h00, 8'hA5};
    vecs[7]  = '{8'h7F, 32'h0,        32, 32'h0,        1'b1, 0, 7'h00, 8'hA5};
    vecs[8]  = '{8'h83, 32'hDEADBEEF, 32, 32'h0,        1'b0, 1, 7'h03, 8'hA5};
    vecs[9]  = '{8'h03, 32'h0,        32, 32'h0,        1'b1, 0, 7'h00, 8'hA5};
    vecs[10] = '{8'h82, 32'hFFFFFFFE, 32, 32'h0,        1'b0, 1, 7'h02, 8'hA5};

    rst = 1'b1; ssel = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_ctrl_during", {24'h0, ctrl}, 32'h01);
    chk("rst_miso_during", {31'h0, miso}, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_ctrl", {24'h0, ctrl}, 32'h01);
    chk("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
    chk("rst_wr_addr", {25'h0, wr_addr}, 32'h0);
    chk("rst_stb_count", stb_total, 0);

    for (int v = 0; v < NV; v++) begin
      sb.push_back('{vecs[v].exp_rd, vecs[v].chk_rd, vecs[v].stb, vecs[v].addr, vecs[v].ctrl});
      s0 = stb_total;
      xfer(vecs[v].cmd, vecs[v].wd, vecs[v].nd, 1'b1, rd);
      repeat (2) @(negedge clk);
      e = sb.pop_front();
      if (e.chk_rd) chk($sformatf("v%0d_rdata", v), rd, e.rd);
      chk($sformatf("v%0d_stb_pulses", v), stb_total - s0, e.stb);
      if (e.stb != 0) chk($sformatf("v%0d_wr_addr", v), {25'h0, wr_addr}, {25'h0, e.addr});
      chk($sformatf("v%0d_ctrl", v), {24'h0, ctrl}, {24'h0, e.ctrl});
    end

    // COUNT was loaded with FFFFFFFE at the last commit; it must have
    // advanced by the elapsed clocks (plus synchroniser latency) and wrapped.
    repeat (100) @(negedge clk);
    xfer(8'h02, 32'h0, 32, 1'b1, rd);
    d  = rd + 32'd2;
    lo = raise8_cyc - stb_cyc;
    total++;
    if (d < 32'(lo) || d > 32'(lo + 6)) begin
      bad++;
      $display("FAIL count_snapshot: got elapsed %0d want %0d..%0d", d, lo, lo + 6);
    end
    total++;
    if (rd >= 32'h200) begin
      bad++;
      $display("FAIL count_wrap: got 0x%08h want below 0x00000200", rd);
    end

    // Reset in the data phase of a CTRL write.
    s0 = stb_total;
    xfer(8'h81, 32'h0000003C, 10, 1'b0, rd);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {24'h0, ctrl}, 32'h01);
    chk("midrst_wr_addr", {25'h0, wr_addr}, 32'h0);
    chk("midrst_miso", {31'h0, miso}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      mosi = 1'b1;
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
    half();
    ssel = 1'b1;
    half();
    half();
    chk("midrst_no_stb", stb_total - s0, 0);
    chk("midrst_ctrl_after", {24'h0, ctrl}, 32'h01);

    s0 = stb_total;
    xfer(8'h81, 32'h0000003C, 32, 1'b1, rd);
    repeat (2) @(negedge clk);
    chk("post_rst_stb", stb_total - s0, 1);
    chk("post_rst_wr_addr", {25'h0, wr_addr}, 32'h01);
    chk("post_rst_ctrl", {24'h0, ctrl}, 32'h3C);
    xfer(8'h03, 32'h0, 32, 1'b1, rd);
    chk("post_rst_status", rd, 32'h00000001);
    xfer(8'h01, 32'h0, 32, 1'b1, rd);
    chk("post_rst_ctrl_read", rd, 32'h0000003C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
